dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the 16-bit-address / 32-bit-data processor data port: it sits on the far side of `dmem_addr` / `dmem_data_out` / `dmem_wr` and returns `dmem_data_in`. It holds a word-addressed synchronous RAM plus a small memory-mapped I/O page: GPIO, a free-running cycle counter and a compare timer with an interrupt flag. Read data is registered, and the processor's MEM stage holds the address for the two cycles it needs.

## Interface
- `RAM_AW`, default 10: RAM word-address width (1024 × 32-bit words).
- `IO_BASE`, default 16'hFF00: first address of the I/O page, which occupies 256 words.
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `dmem_addr` input 16: word address from the processor.
- `dmem_data_out` input 32: write data from the processor.
- `dmem_wr` input 1: write strobe, sampled every cycle.
- `dmem_data_in` output 32: registered read data to the processor.
- `gpio_in` input 16: asynchronous external inputs.
- `gpio_out` output 16: GPIO output register.
- `irq` output 1: equals the timer flag.
- `addr_err` output 1: one-cycle pulse on an access to an unmapped address.

## Operation
- **Decode:**
  - RAM when `dmem_addr < 2**RAM_AW`.
  - I/O when `dmem_addr >= IO_BASE`.
  - Otherwise unmapped.
- **Writes** commit at the rising edge where `dmem_wr=1`.
  - RAM and RW registers are written with `dmem_data_out`; GPIO_OUT and TIMER_CMP are the RW registers.
  - Writes to RO registers are ignored and do not raise `addr_err`.
  - Writes to unmapped addresses are dropped.
- **Reads:** every cycle, `dmem_data_in` is registered from the addressed location, whatever the state of `dmem_wr`. RAM is write-first: a write and a read at the same edge return the new data.
- **I/O map** (offsets from `IO_BASE`):
  - 0x00 GPIO_OUT: RW, bits [15:0]; the upper read bits are 0.
  - 0x01 GPIO_IN: RO, taken after a two-flop synchronizer.
  - 0x02 CYCLE: RO, 32-bit free-running counter that wraps 0xFFFFFFFF → 0.
  - 0x03 TIMER_CMP: RW, 32 bits.
  - 0x04 TIMER_CTRL: bit0 EN, bit1 AUTO, bit2 FLAG. Writing 1 to bit2 clears FLAG; writing 0 to bit2 has no effect.
  - 0x05 TIMER_CNT: RO.
  - 0x06–0xFF: unmapped. Reads return 0 and the access pulses `addr_err`.
- **Timer:** while EN=1, TIMER_CNT increments each cycle.
  - **Match:** when TIMER_CNT==TIMER_CMP, FLAG is set. TIMER_CNT then loads 0. If AUTO=0, EN also clears.
  - **Same-cycle CTRL write and match:** FLAG set wins over clear. EN and AUTO take the written values, but a match with AUTO=0 still forces EN=0.
  - **Writing EN=1** does not reset TIMER_CNT.
  - **TIMER_CMP writes** are used by the compare from the next cycle.
- **Unmapped access** (read or write, including unmapped I/O offsets): `addr_err` asserts in the following cycle, for one cycle. `dmem_data_in` is 0.

## Timing
- Read latency is 1 cycle: the address presented at edge N gives data on `dmem_data_in` after edge N; the processor samples it in its MEM cycle. Back-to-back accesses are supported at one per cycle.
- A write at edge N is readable by a read presented at edge N+1, or at edge N via write-first.
- `gpio_in` to GPIO_IN read-data latency is 3 edges: 2 synchronizer flops plus the read register.
- **Reset values:**
  - `dmem_data_in`, `gpio_out`, `irq`, `addr_err` = 0.
  - CYCLE, TIMER_CNT, TIMER_CMP, TIMER_CTRL = 0; the synchronizers = 0.
  - RAM contents are not reset.
- Reset asserted mid-operation: a write on that same edge is dropped for registers. RAM may take the write; this is not guaranteed.
- CYCLE counts from 0 on the first edge after reset deasserts.

## Configuration
- **`DMEM_TIMER_EN` defined:** TIMER_CMP, TIMER_CTRL, TIMER_CNT and `irq` behave as above.
- **Not defined:**
  - No timer logic is built.
  - Offsets 0x03–0x05 behave as unmapped: reads return 0 and the access pulses `addr_err`.
  - `irq` is tied to 0.
  - CYCLE and GPIO are unaffected.

## Structure
- Package `dmem_pkg` holds:
  - the I/O offset constants (`IO_GPIO_OUT`, `IO_GPIO_IN`, `IO_CYCLE`, `IO_TIMER_CMP`, `IO_TIMER_CTRL`, `IO_TIMER_CNT`);
  - the CTRL bit indices (`CTRL_EN`, `CTRL_AUTO`, `CTRL_FLAG`);
  - a region enum (`REG_RAM`, `REG_IO`, `REG_NONE`).
- One sub-module `dmem_timer` contains CMP/CTRL/CNT, the match logic and FLAG. It is instantiated only under `DMEM_TIMER_EN`.
- RAM, decode, GPIO, CYCLE and the read mux stay in the top level.

## Test plan
- **RAM write/read:** write 0xDEADBEEF to 0x0005, then read 0x0005 → `dmem_data_in`=0xDEADBEEF one cycle after the address is presented. Read 0x0006 returns prior contents, not corrupted.
- **GPIO:** write 0x1234ABCD to 0xFF00 → `gpio_out`=0xABCD, and a read of 0xFF00 returns 0x0000ABCD. Drive `gpio_in`=0x00F0 → reading 0xFF01 three edges later returns 0x000000F0.
- **Timer, AUTO=0:** CMP=3, CTRL=0b001 → FLAG and `irq` set at the match; EN reads 0; TIMER_CNT=0. Write 0b100 to CTRL → `irq`=0.
- **Timer, AUTO=1, simultaneous clear:** CMP=2, CTRL=0b011 → `irq` rises every 3 cycles. A FLAG-clear write on a match edge leaves `irq`=1.
- **Unmapped access:** reads of 0x0800 and 0xFF06 → data 0 and a one-cycle `addr_err` each. A write to 0x0800 leaves RAM unchanged.
- **Reset and wrap:** preload CYCLE near wrap via force, or run 2^32 cycles in a reduced-width build → 0xFFFFFFFF → 0. Assert `reset` mid-timer → all outputs 0 on the next edge.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: I/O page offsets,
// timer control bit positions and the address-region decode.
// Imported by dmem_responder and dmem_timer.
package dmem_pkg;

  // Word offsets inside the I/O page (relative to IO_BASE)
  localparam logic [7:0] IO_GPIO_OUT   = 8'h00;
  localparam logic [7:0] IO_GPIO_IN    = 8'h01;
  localparam logic [7:0] IO_CYCLE      = 8'h02;
  localparam logic [7:0] IO_TIMER_CMP  = 8'h03;
  localparam logic [7:0] IO_TIMER_CTRL = 8'h04;
  localparam logic [7:0] IO_TIMER_CNT  = 8'h05;

  // TIMER_CTRL bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_FLAG = 2;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_IO   = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  // RAM has priority; the I/O page is exactly 256 words starting at io_base,
  // anything else (including addresses above a relocated page) is unmapped.
  function automatic region_e decode_region(input logic [15:0] addr,
                                            input int          ram_aw,
                                            input logic [15:0] io_base);
    logic [15:0] off;
    off = addr - io_base;
    if (32'(addr) < (32'd1 << ram_aw))
      return REG_RAM;
    else if ((addr >= io_base) && (off < 16'd256))
      return REG_IO;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/dmem_timer.sv
// Compare timer: TIMER_CMP / TIMER_CTRL / TIMER_CNT, match detection and the
// sticky FLAG that drives the interrupt. Built only under DMEM_TIMER_EN.
// Ports: clk, reset (sync, active-high), register write strobes + write data,
// register read values (cmp, ctrl, cnt) and flag.
module dmem_timer
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_cmp,
  input  logic        wr_ctrl,
  input  logic [31:0] wdata,
  output logic [31:0] cmp,
  output logic [31:0] ctrl,
  output logic [31:0] cnt,
  output logic        flag
);

  logic en;
  logic auto_mode;
  logic match;

  // Only a running timer can match; otherwise CNT==CMP==0 out of reset would
  // raise the flag immediately.
  assign match = en && (cnt == cmp);

  assign ctrl = {29'd0, flag, auto_mode, en};

  always_ff @(posedge clk) begin
    if (reset) begin
      cmp       <= '0;
      cnt       <= '0;
      en        <= 1'b0;
      auto_mode <= 1'b0;
      flag      <= 1'b0;
    end else begin
      if (wr_cmp)
        cmp <= wdata;
      if (wr_ctrl) begin
        en        <= wdata[CTRL_EN];
        auto_mode <= wdata[CTRL_AUTO];
        if (wdata[CTRL_FLAG])
          flag <= 1'b0;
      end
      // Placed after the CTRL write so a match overrides it: the flag set
      // beats a same-cycle clear, and a one-shot match still stops the timer.
      if (match) begin
        flag <= 1'b1;
        cnt  <= '0;
        if (!auto_mode)
          en <= 1'b0;
      end else if (en) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM plus an I/O page (GPIO, cycle
// counter, optional compare timer when DMEM_TIMER_EN is defined).
// Ports: clk/reset (sync, active-high); dmem_addr/dmem_data_out/dmem_wr from
// the processor; registered dmem_data_in back; gpio_in/gpio_out; irq; addr_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          RAM_AW  = 10,
  parameter logic [15:0] IO_BASE = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dmem_addr,
  input  logic [31:0] dmem_data_out,
  input  logic        dmem_wr,
  output logic [31:0] dmem_data_in,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out,
  output logic        irq,
  output logic        addr_err
);

  localparam int RAM_WORDS = 1 << RAM_AW;

  logic [31:0]       mem [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  region_e           region;
  logic [7:0]        io_off;
  logic              io_mapped;
  logic              unmapped;
  logic              ram_we;
  logic              io_we;
  logic [31:0]       rd_mux;
  logic [15:0]       gpio_s1;
  logic [15:0]       gpio_s2;
  logic [31:0]       cycle_q;

  assign region  = decode_region(dmem_addr, RAM_AW, IO_BASE);
  assign ram_idx = dmem_addr[RAM_AW-1:0];
  assign io_off  = 8'(dmem_addr - IO_BASE);
  assign ram_we  = dmem_wr && (region == REG_RAM);
  assign io_we   = dmem_wr && (region == REG_IO);

`ifdef DMEM_TIMER_EN
  logic [31:0] tmr_cmp;
  logic [31:0] tmr_ctrl;
  logic [31:0] tmr_cnt;
  logic        tmr_flag;

  dmem_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_cmp  (io_we && (io_off == IO_TIMER_CMP)),
    .wr_ctrl (io_we && (io_off == IO_TIMER_CTRL)),
    .wdata   (dmem_data_out),
    .cmp     (tmr_cmp),
    .ctrl    (tmr_ctrl),
    .cnt     (tmr_cnt),
    .flag    (tmr_flag)
  );

  assign irq = tmr_flag;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    io_mapped = 1'b0;
    case (io_off)
      IO_GPIO_OUT,
      IO_GPIO_IN,
      IO_CYCLE:      io_mapped = 1'b1;
`ifdef DMEM_TIMER_EN
      IO_TIMER_CMP,
      IO_TIMER_CTRL,
      IO_TIMER_CNT:  io_mapped = 1'b1;
`endif
      default:       io_mapped = 1'b0;
    endcase
  end

  assign unmapped = (region == REG_NONE) || ((region == REG_IO) && !io_mapped);

  // Read mux. The single port means a RAM write always targets the address
  // being read, so write-first is just a bypass of the write data.
  always_comb begin
    rd_mux = '0;
    case (region)
      REG_RAM: rd_mux = dmem_wr ? dmem_data_out : mem[ram_idx];
      REG_IO: begin
        case (io_off)
          IO_GPIO_OUT:   rd_mux = {16'd0, gpio_out};
          IO_GPIO_IN:    rd_mux = {16'd0, gpio_s2};
          IO_CYCLE:      rd_mux = cycle_q;
`ifdef DMEM_TIMER_EN
          IO_TIMER_CMP:  rd_mux = tmr_cmp;
          IO_TIMER_CTRL: rd_mux = tmr_ctrl;
          IO_TIMER_CNT:  rd_mux = tmr_cnt;
`endif
          default:       rd_mux = '0;
        endcase
      end
      default: rd_mux = '0;
    endcase
  end

  // RAM array has no reset; it may accept a write on a reset edge.
  always_ff @(posedge clk) begin
    if (ram_we)
      mem[ram_idx] <= dmem_data_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out     <= '0;
      gpio_s1      <= '0;
      gpio_s2      <= '0;
      cycle_q      <= '0;
      dmem_data_in <= '0;
      addr_err     <= 1'b0;
    end else begin
      if (io_we && (io_off == IO_GPIO_OUT))
        gpio_out <= dmem_data_out[15:0];
      gpio_s1      <= gpio_in;
      gpio_s2      <= gpio_s1;
      cycle_q      <= cycle_q + 32'd1;
      dmem_data_in <= rd_mux;
      addr_err     <= unmapped;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus a random
// mix of RAM / GPIO / unmapped accesses against a simple memory model.
// Timer scenarios apply when DMEM_TIMER_EN is defined; otherwise the timer
// offsets are checked as unmapped.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_data_out;
  logic        dmem_wr;
  logic [31:0] dmem_data_in;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        irq;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_m [1024];
  bit          ram_v [1024];
  logic [15:0] gpio_m;

  dmem_responder dut (
    .clk           (clk),
    .reset         (reset),
    .dmem_addr     (dmem_addr),
    .dmem_data_out (dmem_data_out),
    .dmem_wr       (dmem_wr),
    .dmem_data_in  (dmem_data_in),
    .gpio_in       (gpio_in),
    .gpio_out      (gpio_out),
    .irq           (irq),
    .addr_err      (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One processor cycle: present the access, let one edge pass, sample 1ns later.
  task automatic access(input logic [15:0] a, input logic w, input logic [31:0] d);
    dmem_addr     = a;
    dmem_wr       = w;
    dmem_data_out = d;
    @(posedge clk);
    #1;
    dmem_wr = 1'b0;
  endtask

  task automatic idle();
    access(16'h0000, 1'b0, 32'h0);
  endtask

  task automatic ram_write(input logic [15:0] a, input logic [31:0] d);
    access(a, 1'b1, d);
    ram_m[a[9:0]] = d;
    ram_v[a[9:0]] = 1'b1;
    check_eq("ram_wr_first", dmem_data_in, d);
    check_eq("ram_wr_err", {31'd0, addr_err}, 32'd0);
  endtask

  task automatic unmapped_access(input string tag, input logic [15:0] a, input logic w);
    access(a, w, $urandom);
    check_eq({tag, "_data"}, dmem_data_in, 32'd0);
    check_eq({tag, "_err"}, {31'd0, addr_err}, 32'd1);
  endtask

  initial begin
    logic [31:0] v;
    logic [15:0] a;
    int          kind;

    for (int i = 0; i < 1024; i++) ram_v[i] = 1'b0;
    reset = 1'b1; dmem_addr = 16'h0800; dmem_wr = 1'b0; dmem_data_out = '0; gpio_in = '0;
    gpio_m = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_eq("rst_data", dmem_data_in, 32'd0);
    check_eq("rst_gpio", {16'd0, gpio_out}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    check_eq("rst_err", {31'd0, addr_err}, 32'd0);
    reset = 1'b0;

    // RAM write / read, neighbour not corrupted
    ram_write(16'h0000, 32'h1111_1111);
    ram_write(16'h0006, 32'h0BAD_F00D);
    ram_write(16'h0005, 32'hDEAD_BEEF);
    access(16'h0005, 1'b0, 32'h0);
    check_eq("ram_rd5", dmem_data_in, 32'hDEAD_BEEF);
    access(16'h0006, 1'b0, 32'h0);
    check_eq("ram_rd6", dmem_data_in, 32'h0BAD_F00D);

    // GPIO out
    access(16'hFF00, 1'b1, 32'h1234_ABCD);
    gpio_m = 16'hABCD;
    check_eq("gpio_out", {16'd0, gpio_out}, 32'h0000_ABCD);
    access(16'hFF00, 1'b0, 32'h0);
    check_eq("gpio_out_rd", dmem_data_in, 32'h0000_ABCD);

    // GPIO in: visible on the third edge
    gpio_in = 16'h00F0;
    access(16'hFF01, 1'b0, 32'h0);
    access(16'hFF01, 1'b0, 32'h0);
    check_eq("gpio_in_2edges", dmem_data_in, 32'h0);
    access(16'hFF01, 1'b0, 32'h0);
    check_eq("gpio_in_3edges", dmem_data_in, 32'h0000_00F0);

    // Cycle counter advances by one per edge
    access(16'hFF02, 1'b0, 32'h0);
    v = dmem_data_in;
    access(16'hFF02, 1'b0, 32'h0);
    check_eq("cycle_step", dmem_data_in - v, 32'd1);

    // Unmapped accesses
    unmapped_access("unm_0800", 16'h0800, 1'b0);
    idle();
    check_eq("unm_pulse_end", {31'd0, addr_err}, 32'd0);
    unmapped_access("unm_ff06", 16'hFF06, 1'b0);
    idle();
    check_eq("unm_pulse_end2", {31'd0, addr_err}, 32'd0);
    unmapped_access("unm_wr0800", 16'h0800, 1'b1);
    access(16'h0000, 1'b0, 32'h0);
    check_eq("ram0_intact", dmem_data_in, 32'h1111_1111);

`ifdef DMEM_TIMER_EN
    // One-shot: CMP=3, match on the 4th edge after enabling
    access(16'hFF03, 1'b1, 32'd3);
    access(16'hFF03, 1'b0, 32'h0);
    check_eq("tmr_cmp_rd", dmem_data_in, 32'd3);
    access(16'hFF04, 1'b1, 32'b001);
    for (int k = 1; k <= 4; k++) begin
      idle();
      check_eq($sformatf("tmr_os_irq%0d", k), {31'd0, irq}, (k == 4) ? 32'd1 : 32'd0);
    end
    access(16'hFF04, 1'b0, 32'h0);
    check_eq("tmr_os_ctrl", dmem_data_in, 32'b100);
    access(16'hFF05, 1'b0, 32'h0);
    check_eq("tmr_os_cnt", dmem_data_in, 32'd0);
    check_eq("tmr_os_irq_hold", {31'd0, irq}, 32'd1);
    access(16'hFF04, 1'b1, 32'b100);
    check_eq("tmr_os_clear", {31'd0, irq}, 32'd0);

    // Auto-reload: CMP=2 -> match every 3 edges
    access(16'hFF03, 1'b1, 32'd2);
    access(16'hFF04, 1'b1, 32'b011);
    idle(); check_eq("tmr_ar_w1", {31'd0, irq}, 32'd0);
    idle(); check_eq("tmr_ar_w2", {31'd0, irq}, 32'd0);
    idle(); check_eq("tmr_ar_w3", {31'd0, irq}, 32'd1);
    access(16'hFF04, 1'b1, 32'b111);
    check_eq("tmr_ar_w4", {31'd0, irq}, 32'd0);
    idle(); check_eq("tmr_ar_w5", {31'd0, irq}, 32'd0);
    idle(); check_eq("tmr_ar_w6", {31'd0, irq}, 32'd1);
    idle(); idle();
    access(16'hFF04, 1'b1, 32'b111);
    check_eq("tmr_ar_setwins", {31'd0, irq}, 32'd1);
    access(16'hFF04, 1'b1, 32'b111);
    check_eq("tmr_ar_clr", {31'd0, irq}, 32'd0);
    access(16'hFF04, 1'b1, 32'b100);
`else
    unmapped_access("unm_cmp", 16'hFF03, 1'b1);
    unmapped_access("unm_ctrl", 16'hFF04, 1'b0);
    unmapped_access("unm_cnt", 16'hFF05, 1'b0);
    check_eq("irq_tied", {31'd0, irq}, 32'd0);
`endif

    // Randomised mix against the model
    for (int it = 0; it < 300; it++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin
          a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 31)) : 16'($urandom_range(992, 1023));
          ram_write(a, $urandom);
        end
        1: begin
          a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 31)) : 16'($urandom_range(992, 1023));
          access(a, 1'b0, 32'h0);
          if (ram_v[a[9:0]]) check_eq("rnd_ram_rd", dmem_data_in, ram_m[a[9:0]]);
          check_eq("rnd_ram_err", {31'd0, addr_err}, 32'd0);
        end
        2: begin
          v = $urandom;
          access(16'hFF00, 1'b1, v);
          gpio_m = v[15:0];
          check_eq("rnd_gpio_out", {16'd0, gpio_out}, {16'd0, gpio_m});
          check_eq("rnd_gpio_err", {31'd0, addr_err}, 32'd0);
        end
        3: begin
          access(16'hFF00, 1'b0, 32'h0);
          check_eq("rnd_gpio_rd", dmem_data_in, {16'd0, gpio_m});
        end
        4: unmapped_access("rnd_unm_gap", 16'($urandom_range(16'h0400, 16'hFEFF)), 1'($urandom_range(0, 1)));
        default: begin
`ifdef DMEM_TIMER_EN
          a = 16'($urandom_range(16'hFF06, 16'hFFFF));
`else
          a = 16'($urandom_range(16'hFF03, 16'hFFFF));
`endif
          unmapped_access("rnd_unm_io", a, 1'($urandom_range(0, 1)));
        end
      endcase
    end

    // Cycle counter wrap
    force dut.cycle_q = 32'hFFFF_FFFD;
    #1;
    release dut.cycle_q;
    access(16'hFF02, 1'b0, 32'h0); check_eq("wrap_fd", dmem_data_in, 32'hFFFF_FFFD);
    access(16'hFF02, 1'b0, 32'h0); check_eq("wrap_fe", dmem_data_in, 32'hFFFF_FFFE);
    access(16'hFF02, 1'b0, 32'h0); check_eq("wrap_ff", dmem_data_in, 32'hFFFF_FFFF);
    access(16'hFF02, 1'b0, 32'h0); check_eq("wrap_00", dmem_data_in, 32'h0000_0000);
    access(16'hFF02, 1'b0, 32'h0); check_eq("wrap_01", dmem_data_in, 32'h0000_0001);

    // Reset in the middle of activity
    access(16'hFF00, 1'b1, 32'h0000_FFFF);
`ifdef DMEM_TIMER_EN
    access(16'hFF03, 1'b1, 32'd0);
    access(16'hFF04, 1'b1, 32'b011);
    idle();
    check_eq("pre_rst_irq", {31'd0, irq}, 32'd1);
`endif
    reset = 1'b1;
    access(16'h0800, 1'b1, 32'hCAFE_CAFE);
    check_eq("mid_rst_data", dmem_data_in, 32'd0);
    check_eq("mid_rst_gpio", {16'd0, gpio_out}, 32'd0);
    check_eq("mid_rst_irq", {31'd0, irq}, 32'd0);
    check_eq("mid_rst_err", {31'd0, addr_err}, 32'd0);
    reset = 1'b0;
    access(16'hFF02, 1'b0, 32'h0);
    check_eq("cycle_after_rst", dmem_data_in, 32'd0);
    repeat (4) idle();
    check_eq("irq_after_rst", {31'd0, irq}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
